// File: rtl/cache_miss_ctrl.sv
// 8-set, 2-way write-back cache controller with a request/done CPU handshake.
// It sequences victim write-back and line refill over a variable-latency req/ack memory port.
module cache_miss_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int SET_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [2:0]        dbg_state
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  // Handshakes: cpu_req is held until the one-cycle cpu_done pulse; mem_req is
  // held until a one-cycle mem_ack, and mem_ack is only honoured while mem_req=1.
  state_t state, state_d;

  logic [TAG_W-1:0]  tag_q   [2][NSETS];
  logic [DATA_W-1:0] data_q  [2][NSETS];
  logic [NSETS-1:0]  valid_q [2];
  logic [NSETS-1:0]  dirty_q [2];
  logic [NSETS-1:0]  lru_q;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              vic_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit0, hit1, hit_any, hit_way, vic_sel, vic_dirty;

  logic              mem_req_d, mem_we_d, cpu_done_d, cpu_hit_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, cpu_rdata_d;
  logic              accept, lookup_hit, lookup_miss, wb_done, fill_done;

  assign set_idx   = req_addr[SET_BITS-1:0];
  assign req_tag   = req_addr[ADDR_W-1:SET_BITS];
  assign hit0      = valid_q[0][set_idx] && (tag_q[0][set_idx] == req_tag);
  assign hit1      = valid_q[1][set_idx] && (tag_q[1][set_idx] == req_tag);
  assign hit_any   = hit0 || hit1;
  assign hit_way   = ~hit0;
  // Invalid ways are filled first (way0 before way1); otherwise the LRU way is evicted.
  assign vic_sel   = !valid_q[0][set_idx] ? 1'b0 :
                     !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];
  assign vic_dirty = valid_q[vic_sel][set_idx] && dirty_q[vic_sel][set_idx];
  assign dbg_state = state;

  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_done_d  = 1'b0;
    cpu_hit_d   = cpu_hit;
    cpu_rdata_d = cpu_rdata;
    accept      = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    wb_done     = 1'b0;
    fill_done   = 1'b0;
    case (state)
      S_IDLE: begin
        // The done cycle itself never accepts, so a still-held cpu_req is not re-taken.
        if (cpu_req && !cpu_done) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          lookup_hit = 1'b1;
          cpu_hit_d  = 1'b1;
          if (!req_we) cpu_rdata_d = data_q[hit_way][set_idx];
          state_d    = S_RESPOND;
        end else begin
          lookup_miss = 1'b1;
          cpu_hit_d   = 1'b0;
          mem_req_d   = 1'b1;
          if (vic_dirty) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[vic_sel][set_idx], set_idx};
            mem_wdata_d = data_q[vic_sel][set_idx];
            state_d     = S_WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = req_addr;
            state_d    = S_REFILL;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_req && mem_ack) begin
          wb_done   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        // Arriving from write-back, mem_req is low for one cycle before the refill request.
        if (!mem_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr;
        end else if (mem_ack) begin
          fill_done = 1'b1;
          mem_req_d = 1'b0;
          if (!req_we) cpu_rdata_d = mem_rdata;
          state_d   = S_RESPOND;
        end
      end
      S_RESPOND: begin
        cpu_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      vic_q      <= 1'b0;
    end else begin
      state     <= state_d;
      cpu_done  <= cpu_done_d;
      cpu_hit   <= cpu_hit_d;
      cpu_rdata <= cpu_rdata_d;
      busy      <= (state_d != S_IDLE);
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if (accept) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (lookup_hit) begin
        lru_q[set_idx] <= ~hit_way;
        if (req_we) dirty_q[hit_way][set_idx] <= 1'b1;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      if (lookup_miss) begin
        vic_q <= vic_sel;
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      if (wb_done) dirty_q[vic_q][set_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[vic_q][set_idx] <= 1'b1;
        dirty_q[vic_q][set_idx] <= req_we;
        lru_q[set_idx]          <= ~vic_q;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (lookup_hit && req_we) data_q[hit_way][set_idx] <= req_wdata;
    if (fill_done) begin
      tag_q[vic_q][set_idx]  <= req_tag;
      data_q[vic_q][set_idx] <= req_we ? req_wdata : mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed vector table, reset-abort sequence and random traffic,
// checked against an architectural memory image plus a set/way residency model.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [5:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_done, cpu_hit, busy, mem_req, mem_we, mem_ack;
  logic [7:0]  cpu_rdata, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;
  logic [15:0] hit_count, miss_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Backing RAM (what memory holds) and the architectural view the CPU should see.
  logic [7:0]  ram  [64];
  logic [7:0]  arch [64];
  logic [7:0]  snap [64];
  logic        m_valid [8][2];
  logic        m_dirty [8][2];
  logic [2:0]  m_tag   [8][2];
  logic        m_lru   [8];
  int          m_hits, m_misses;
  logic [14:0] exp_q[$];   // {we, addr[5:0], wdata[7:0]} of expected memory transfers

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         dly;
    logic       exp_hit;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t tbl[9];

  logic       op_we [12];
  logic [5:0] op_addr [12];
  logic [7:0] op_wd [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 3'd0;
      end
    end
    for (int a = 0; a < 64; a++) arch[a] = ram[a];
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  task automatic model_access(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                              output logic hit, output logic [7:0] rd);
    int s, w, v;
    logic [5:0] va;
    s = int'(addr[2:0]);
    w = -1;
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == addr[5:3]) w = i;
    if (w >= 0) begin
      hit = 1'b1;
      m_lru[s] = (w == 0);
      if (we) m_dirty[s][w] = 1'b1;
      if (m_hits < 65535) m_hits++;
    end else begin
      hit = 1'b0;
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : (m_lru[s] ? 1 : 0));
      if (m_valid[s][v] && m_dirty[s][v]) begin
        va = {m_tag[s][v], addr[2:0]};
        exp_q.push_back({1'b1, va, arch[va]});
      end
      exp_q.push_back({1'b0, addr, 8'h00});
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = addr[5:3];
      m_dirty[s][v] = we;
      m_lru[s]      = (v == 0);
      if (m_misses < 65535) m_misses++;
    end
    rd = arch[addr];
    if (we) arch[addr] = wd;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  // One CPU request with a memory responder that acks after dly waiting cycles.
  task automatic run_req(input logic we, input logic [5:0] addr, input logic [7:0] wd, input int dly,
                         input bit use_tbl, input logic tbl_hit, input logic [7:0] tbl_rd);
    logic e_hit;
    logic [7:0] e_rd;
    logic [14:0] e;
    int cyc, wait_cnt, ack_cyc, wb_cyc;
    bit in_tx, done;
    model_access(we, addr, wd, e_hit, e_rd);
    @(posedge clk);
    #1;
    check("done_pulse_width", cpu_done, 1'b0);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cyc = 0; in_tx = 0; done = 0; ack_cyc = -100; wb_cyc = -100; wait_cnt = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 1) begin
        cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wd;
      end
      if (cpu_done) done = 1;
      else if (mem_req) begin
        if (!in_tx) begin
          in_tx = 1;
          wait_cnt = dly;
          if (exp_q.size() == 0) check("mem_tx_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("mem_we", mem_we, e[14]);
            check("mem_addr", mem_addr, e[13:8]);
            if (e[14]) check("mem_wdata", mem_wdata, e[7:0]);
            else if (wb_cyc > 0) check("wb_refill_gap", cyc - wb_cyc, 2);
          end
        end
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = ram[mem_addr];
          if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            wb_cyc = cyc;
          end
          ack_cyc = cyc;
          in_tx = 0;
        end else wait_cnt--;
      end
    end
    cpu_req = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    else begin
      check("cpu_hit", cpu_hit, e_hit);
      if (!we) check("cpu_rdata", cpu_rdata, e_rd);
      if (use_tbl) begin
        check("tbl_hit", cpu_hit, tbl_hit);
        if (!we) check("tbl_rdata", cpu_rdata, tbl_rd);
      end
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
      check("busy_at_done", busy, 1'b0);
      if (e_hit) check("hit_latency", cyc, 3);
      else check("miss_latency", cyc - ack_cyc, 2);
      check("mem_tx_missing", exp_q.size(), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    logic [5:0] ra;
    tbl[0] = '{1'b0, 6'h05, 8'h00, 3, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 6'h05, 8'h00, 0, 1'b1, 8'hA5};
    tbl[2] = '{1'b1, 6'h05, 8'h3C, 0, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 6'h0D, 8'h00, 1, 1'b0, 8'h11};
    tbl[4] = '{1'b0, 6'h15, 8'h00, 2, 1'b0, 8'h77};
    tbl[5] = '{1'b1, 6'h22, 8'h5A, 0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 6'h22, 8'h00, 0, 1'b1, 8'h5A};
    tbl[7] = '{1'b0, 6'h2A, 8'h00, 7, 1'b0, 8'h61};
    tbl[8] = '{1'b0, 6'h32, 8'h00, 0, 1'b0, 8'h62};

    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    for (int a = 0; a < 64; a++) ram[a] = 8'($urandom);
    ram[6'h05] = 8'hA5; ram[6'h0D] = 8'h11; ram[6'h15] = 8'h77;
    ram[6'h22] = 8'hFF; ram[6'h2A] = 8'h61; ram[6'h32] = 8'h62;

    do_reset();
    check("rst_cpu_done", cpu_done, 0);
    check("rst_cpu_hit", cpu_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    for (int i = 0; i < 9; i++)
      run_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dly, 1'b1, tbl[i].exp_hit, tbl[i].exp_rdata);

    // Same traffic with zero-wait and 7-cycle acks from an identical memory image.
    for (int i = 0; i < 12; i++) begin
      op_we[i] = 1'($urandom);
      op_addr[i] = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 1))};
      op_wd[i] = 8'($urandom);
    end
    for (int a = 0; a < 64; a++) snap[a] = ram[a];
    for (int run = 0; run < 2; run++) begin
      for (int a = 0; a < 64; a++) ram[a] = snap[a];
      do_reset();
      for (int i = 0; i < 12; i++)
        run_req(op_we[i], op_addr[i], op_wd[i], (run == 0) ? 0 : 7, 1'b0, 1'b0, 8'h00);
    end

    // Reset while a refill is outstanding, then a stray ack.
    do_reset();
    ram[6'h05] = 8'hA5;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      if (mem_req) seen = 1;
    end
    check("abort_mem_req_seen", seen, 1);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    check("abort_mem_req", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", cpu_done, 0);
    check("abort_miss_count", miss_count, 0);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("stray_ack_mem_req", mem_req, 0);
    check("stray_ack_busy", busy, 0);
    check("stray_ack_done", cpu_done, 0);
    model_reset();
    run_req(1'b0, 6'h05, 8'h00, 2, 1'b1, 1'b0, 8'hA5);

    // Random traffic concentrated on two sets to force evictions.
    for (int i = 0; i < 60; i++) begin
      ra = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ra[2:1] = 2'b00;
      run_req(1'($urandom), ra, 8'($urandom), $urandom_range(0, 4), 1'b0, 1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Cache controller for the 8-set, 2-way, 6-bit-address, 8-bit-data write-back cache. It owns the tag/valid/dirty/LRU/data arrays and runs a request/done handshake toward the processor. On a miss it sequences a dirty-victim write-back and then a line refill over a variable-latency req/ack memory port. It replaces the single-cycle, implicitly-timed cache update with an explicit FSM, so the RAM may take any number of cycles.

Parameters:
ADDR_W, 6, byte address width; set index = addr[2:0], tag = addr[ADDR_W-1:3]
DATA_W, 8, data/line width (one word per line)
SET_BITS, 3, index width; 2**SET_BITS sets, 2 ways each
CNT_W, 16, width of hit/miss statistics counters (saturating)

Ports:
clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  request valid; held until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_done (read requests)
cpu_hit  out  1  with cpu_done: 1 = request hit
busy  out  1  high whenever FSM is not IDLE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write-back, 0 = refill read
mem_addr  out  ADDR_W  {tag, set} of the line transferred
mem_wdata  out  DATA_W  victim data during write-back
mem_rdata  in  DATA_W  refill data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge; only meaningful while mem_req=1
hit_count  out  CNT_W  completed hits, saturates at all-ones
miss_count  out  CNT_W  completed misses, saturates

Behaviour:
- Reset (clk edge with Reset=1): all valid, dirty, and LRU bits become 0; data/tag arrays are don't-care; FSM enters IDLE. cpu_done, cpu_hit, busy, mem_req, mem_we, and both counters are 0; cpu_rdata, mem_addr, and mem_wdata are 0. Reset overrides any state; an in-flight memory transaction is abandoned (mem_req=0 after the edge), and a later mem_ack is ignored.
- All outputs are registered.
- LRU bit per set names the next victim way (0 = way0). Any access or fill of way w sets LRU = ~w.
- Victim selection: invalid way0 first, then invalid way1, otherwise the LRU way.
- IDLE: if cpu_req=1, latch we/addr/wdata, set busy, go to LOOKUP; otherwise stay.
- LOOKUP: compare the latched tag with both valid ways of the set.
  - Hit, read: cpu_rdata = line.
  - Hit, write: line = wdata, dirty = 1.
  - Either hit: update LRU, hit_count++, go to RESPOND with cpu_hit=1.
  - Miss: miss_count++. If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, set}, mem_wdata = victim data. On mem_ack: clear victim dirty, drop mem_req, go to REFILL (mem_req reasserts the next cycle).
- REFILL: mem_req=1, mem_we=0, mem_addr = latched addr. On mem_ack, the victim line gets tag = latched tag, valid = 1, and LRU is updated.
  - Read: data = mem_rdata, dirty = 0, cpu_rdata = mem_rdata.
  - Write: data = cpu_wdata (mem_rdata discarded), dirty = 1.
  - Then go to RESPOND with cpu_hit=0.
- RESPOND: cpu_done=1 for exactly one cycle, busy drops, return to IDLE. A new request can be accepted on the cycle after cpu_done.
- Latency:
  - Hit: cpu_done is 2 cycles after the IDLE accept edge.
  - Clean miss: cpu_done 1 cycle after the refill mem_ack.
  - Dirty miss: write-back, one idle cycle, then refill.
- mem_ack may arrive in the first cycle mem_req is high (zero wait). mem_ack while mem_req=0 is ignored.
- Counters saturate and never wrap.
- cpu_req changes while busy are ignored; the latched values are used.

Test Plan:
1. Reset; read 0x05, mem_ack after 3 cycles with mem_rdata=0xA5 -> one mem read at addr 0x05; cpu_done with cpu_rdata=0xA5, cpu_hit=0; miss_count=1.
2. Repeat read 0x05 -> no mem_req; cpu_done 2 cycles after accept, rdata=0xA5, cpu_hit=1; hit_count=1.
3. Write 0x05=0x3C (hit), read 0x0D (mem_rdata 0x11, fills way1), read 0x15 -> write-back at addr 0x05 with data 0x3C precedes refill at 0x15; no write-back for 0x0D.
4. Write miss to 0x22 (clean) with mem_rdata=0xFF -> refill read at 0x22; a later read of 0x22 hits with 0x(write data), not 0xFF; a subsequent eviction writes it back.
5. mem_ack zero-wait vs 7-cycle wait on the same sequence -> identical cpu_rdata values and counters; only cpu_done timing differs.
6. Assert Reset mid-REFILL, then pulse mem_ack -> mem_req=0 after the reset edge, stray ack ignored, busy=0; read 0x05 misses (valid cleared); counters restart at 0/1.
